// File: rtl/permutation_ctrl.sv
// Round sequencer for the ASCON permutation: owns the 320-bit state register and the
// round counter, loading one externally computed round result per clock.
module permutation_ctrl #(
    parameter int unsigned NB_ROUNDS_MAX = 12
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       rounds_i,
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] perm_state_o,
    output logic [3:0]       round_o,
    input  logic [4:0][63:0] round_result_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             err_o,
    output logic [4:0][63:0] state_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

    localparam logic [3:0] RoundsMax = 4'(NB_ROUNDS_MAX);
    localparam logic [3:0] LastRound = 4'(NB_ROUNDS_MAX - 1);

    fsm_e             fsm_q;
    logic [3:0]       rnd_cnt_q;
    logic [4:0][63:0] state_q;
    logic             done_q;
    logic             err_q;
    logic             rounds_legal;

    assign rounds_legal = (rounds_i != 4'd0) && (rounds_i <= RoundsMax);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q     <= StIdle;
            rnd_cnt_q <= 4'd0;
            state_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (fsm_q)
                StIdle: begin
                    if (start_i) begin
                        if (rounds_legal) begin
                            state_q   <= state_i;
                            // Start part-way through the constant table so p^b uses 6..11.
                            rnd_cnt_q <= RoundsMax - rounds_i;
                            fsm_q     <= StRun;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    state_q <= round_result_i;
                    if (rnd_cnt_q == LastRound) begin
                        fsm_q  <= StDone;
                        done_q <= 1'b1;
                    end else begin
                        rnd_cnt_q <= rnd_cnt_q + 4'd1;
                    end
                end
                StDone: fsm_q <= StIdle;
                default: fsm_q <= StIdle;
            endcase
        end
    end

    assign ready_o      = (fsm_q == StIdle);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign round_o      = rnd_cnt_q;
    assign perm_state_o = state_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_permutation_ctrl.sv
// Self-checking bench for permutation_ctrl: stub and real ASCON round datapaths, with a
// behavioural p^R model driven from randomized states and round counts.
module tb_permutation_ctrl;

    typedef logic [4:0][63:0] st_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] rounds;
    st_t        st_in;
    st_t        perm_st;
    st_t        rres;
    st_t        st_out;
    logic [3:0] rnd;
    logic       ready;
    logic       done;
    logic       err;
    logic       use_stub;

    int  n_checks = 0;
    int  n_pass = 0;
    st_t exp_state;

    always #5 clk = ~clk;

    permutation_ctrl #(.NB_ROUNDS_MAX(12)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .start_i       (start),
        .rounds_i      (rounds),
        .state_i       (st_in),
        .perm_state_o  (perm_st),
        .round_o       (rnd),
        .round_result_i(rres),
        .ready_o       (ready),
        .done_o        (done),
        .err_o         (err),
        .state_o       (st_out)
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic st_t ascon_round(input st_t s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [3:0]  rc;
        st_t         o;
        rc = 4'hF - r;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x2 = x2 ^ {56'd0, rc, r};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        o[2] = x2 ^ ror(x2, 1) ^ ror(x2, 6);
        o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        o[4] = x4 ^ ror(x4, 7) ^ ror(x4, 41);
        return o;
    endfunction

    // p^R applies the last R constants of the 12-entry table.
    function automatic st_t p_model(input st_t s, input int r);
        st_t x = s;
        for (int i = 0; i < r; i++) x = ascon_round(x, 4'(12 - r + i));
        return x;
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    always_comb begin
        rres = perm_st;
        if (use_stub) rres[0] = perm_st[0] + 64'd1;
        else rres = ascon_round(perm_st, rnd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one start request across a single edge, then scrambles the inputs.
    task automatic launch(input logic [3:0] r, input st_t s);
        start  = 1'b1;
        rounds = r;
        st_in  = s;
        step();
        start  = 1'b0;
        rounds = 4'($urandom);
        st_in  = rand_state();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        rounds = 4'd12;
        st_in = rand_state();
        step();
        step();
        rst = 1'b0;
        exp_state = '0;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_checks++;
        if (rnd !== 4'd0) $display("FAIL reset_round: got %0d want 0", rnd); else n_pass++;
        n_checks++;
        if (st_out !== st_t'(0)) $display("FAIL reset_state: got %h want 0", st_out);
        else n_pass++;
    endtask

    task automatic test_pa_stub();
        st_t s = rand_state();
        st_t e;
        use_stub = 1'b1;
        s[0] = 64'h100;
        e = s;
        e[0] = 64'h10C;
        launch(4'd12, s);
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (rnd !== 4'(i) || ready !== 1'b0 || done !== 1'b0)
                $display("FAIL pa_round%0d: got round=%0d ready=%b done=%b want %0d/0/0",
                         i, rnd, ready, done, i);
            else n_pass++;
            step();
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL pa_done: got %b want 1", done); else n_pass++;
        n_checks++;
        if (st_out !== e || perm_st !== e)
            $display("FAIL pa_state: got w0=%h want w0=%h", st_out[0], e[0]);
        else n_pass++;
        step();
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || st_out !== e)
            $display("FAIL pa_after: got ready=%b done=%b want 1/0 with state held", ready, done);
        else n_pass++;
        exp_state = e;
    endtask

    task automatic test_pb_stub();
        st_t s = rand_state();
        st_t e;
        use_stub = 1'b1;
        s[0] = 64'h0;
        e = s;
        e[0] = 64'h6;
        launch(4'd6, s);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rnd !== 4'(6 + i) || done !== 1'b0)
                $display("FAIL pb_round%0d: got round=%0d done=%b want %0d/0",
                         i, rnd, done, 6 + i);
            else n_pass++;
            step();
        end
        n_checks++;
        if (done !== 1'b1 || st_out !== e)
            $display("FAIL pb_done: got done=%b w0=%h want 1 w0=%h", done, st_out[0], e[0]);
        else n_pass++;
        step();
        n_checks++;
        if (ready !== 1'b1) $display("FAIL pb_ready: got %b want 1", ready); else n_pass++;
        exp_state = e;
    endtask

    task automatic test_illegal();
        logic [3:0] bad [5];
        bad[0] = 4'd0; bad[1] = 4'd13; bad[2] = 4'd14; bad[3] = 4'd15;
        bad[4] = 4'($urandom_range(13, 15));
        for (int k = 0; k < 5; k++) begin
            launch(bad[k], rand_state());
            n_checks++;
            if (err !== 1'b1 || ready !== 1'b1 || st_out !== exp_state)
                $display("FAIL illegal%0d_err: got err=%b ready=%b want 1/1, state unchanged",
                         bad[k], err, ready);
            else n_pass++;
            step();
            n_checks++;
            if (err !== 1'b0 || ready !== 1'b1 || done !== 1'b0)
                $display("FAIL illegal%0d_pulse: got err=%b ready=%b done=%b want 0/1/0",
                         bad[k], err, ready, done);
            else n_pass++;
        end
    endtask

    task automatic test_busy_start();
        st_t s = rand_state();
        st_t e;
        use_stub = 1'b1;
        e = s;
        e[0] = s[0] + 64'd12;
        launch(4'd12, s);
        for (int i = 0; i < 12; i++) begin
            start  = (i == 2);
            rounds = 4'd6;
            st_in  = rand_state();
            n_checks++;
            if (rnd !== 4'(i) || done !== 1'b0)
                $display("FAIL busy_round%0d: got round=%0d done=%b want %0d/0", i, rnd, done, i);
            else n_pass++;
            step();
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || st_out !== e)
            $display("FAIL busy_done: got done=%b w0=%h want 1 w0=%h", done, st_out[0], e[0]);
        else n_pass++;
        step();
        exp_state = e;
    endtask

    task automatic test_reset_midrun();
        st_t s;
        st_t e;
        logic saw_done;
        use_stub = 1'b1;
        launch(4'd12, rand_state());
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || rnd !== 4'd0 || st_out !== st_t'(0))
            $display("FAIL midrun_reset: got ready=%b done=%b round=%0d want 1/0/0, state 0",
                     ready, done, rnd);
        else n_pass++;
        saw_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (done === 1'b1 || ready !== 1'b1) saw_done = 1'b1;
            step();
        end
        n_checks++;
        if (saw_done !== 1'b0) $display("FAIL midrun_nodone: got done/busy=1 want 0");
        else n_pass++;
        s = rand_state();
        e = s;
        e[0] = s[0] + 64'd6;
        launch(4'd6, s);
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (done !== 1'b1 || st_out !== e)
            $display("FAIL midrun_restart: got done=%b w0=%h want 1 w0=%h", done, st_out[0], e[0]);
        else n_pass++;
        step();
        exp_state = e;
    endtask

    // Real round datapath; each run is issued the cycle ready_o returns.
    task automatic test_back_to_back();
        use_stub = 1'b0;
        for (int k = 0; k < 8; k++) begin
            int  r;
            st_t s;
            st_t e;
            r = (k == 0) ? 12 : (k == 1) ? 6 : int'($urandom_range(1, 12));
            s = rand_state();
            if (k == 0) s[0] = 64'h80400c0600000000;
            e = p_model(s, r);
            launch(4'(r), s);
            for (int i = 0; i < r; i++) begin
                n_checks++;
                if (rnd !== 4'(12 - r + i) || done !== 1'b0)
                    $display("FAIL b2b%0d_round%0d: got round=%0d done=%b want %0d/0",
                             k, i, rnd, done, 12 - r + i);
                else n_pass++;
                step();
            end
            n_checks++;
            if (done !== 1'b1 || st_out !== e)
                $display("FAIL b2b%0d_result: got done=%b state=%h want 1 state=%h",
                         k, done, st_out, e);
            else n_pass++;
            step();
            n_checks++;
            if (ready !== 1'b1 || st_out !== e)
                $display("FAIL b2b%0d_ready: got ready=%b want 1 with state held", k, ready);
            else n_pass++;
            exp_state = e;
        end
    endtask

    initial begin
        use_stub = 1'b1;
        rst = 1'b1;
        start = 1'b0;
        rounds = 4'd0;
        st_in = '0;
        test_reset();
        test_pa_stub();
        test_pb_stub();
        test_illegal();
        test_busy_start();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish within 20000 cycles");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/permutation_ctrl.md
# permutation_ctrl

Round sequencer for the ASCON permutation p^a / p^b. It owns the 320-bit permutation state register and the round counter. It feeds the external one-round datapath (constant addition, then the 64-column S-box substitution layer, then the linear diffusion layer) and loads that datapath's result back each cycle, executing one round per clock. It sits between the mode FSM (initialization, associated data, plaintext, finalization) and the combinational round logic.

## Interface
Parameters:
- NB_ROUNDS_MAX, 12: highest round count accepted; also the base for the round-constant index.

Ports:
- clock_i  in  1  system clock; all logic is on the rising edge.
- reset_i  in  1  synchronous reset, active-high.
- start_i  in  1  request a permutation. Sampled only while ready_o=1.
- rounds_i  in  4  number of rounds R. Legal range is 1..12: 12 for p^a, 6 for p^b.
- state_i  in  type_state (5x64)  initial state, captured together with start_i.
- perm_state_o  out  type_state  current state register, driven to the round datapath.
- round_o  out  4  round-constant index for the constant-addition stage.
- round_result_i  in  type_state  combinational one-round result computed from perm_state_o and round_o.
- ready_o  out  1  controller is idle and accepts start_i.
- done_o  out  1  one-cycle pulse; state_o is final.
- err_o  out  1  one-cycle pulse; start_i was rejected because rounds_i was illegal.
- state_o  out  type_state  permutation result; equals the state register.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - start_i=1 with 1<=rounds_i<=12: state_reg<=state_i, rnd_cnt<=12-rounds_i, next state RUN.
  - start_i=1 with rounds_i=0 or rounds_i>12: err_o=1 in the next cycle, state_reg unchanged, stay in IDLE.
- RUN:
  - Every cycle: state_reg<=round_result_i and rnd_cnt<=rnd_cnt+1.
  - When rnd_cnt=11, the same edge moves the FSM to DONE. rnd_cnt stays at 11; it does not wrap.
- DONE: done_o=1 for exactly one cycle, then unconditional transition to IDLE.
- round_o=rnd_cnt in every state. During RUN it steps 12-R, ..., 11, so p^b uses constants 6..11 as the ASCON spec requires.
- start_i in RUN or DONE is ignored: no queueing, no error.
- state_o / perm_state_o hold the result from DONE through IDLE until the next accepted start overwrites state_reg.
- rnd_cnt is 4 bits. The arithmetic 12-rounds_i is evaluated only for legal values, so it never underflows.

## Timing
- Reset (reset_i=1 at an edge): FSM=IDLE, rnd_cnt=0, state_reg=0, done_o=0, err_o=0. In the cycle after reset, ready_o=1, round_o=0 and state_o=0.
- reset_i asserted during RUN or DONE aborts the permutation: no done_o, state_reg is cleared, IDLE follows on the next cycle.
- start_i accepted at edge t:
  - RUN occupies cycles t+1..t+R, one round per cycle.
  - done_o=1 in cycle t+R+1.
  - ready_o=1 again from cycle t+R+2.
  - Total latency is R+1 cycles; the issue interval is R+2 cycles.
- Latency examples: R=12 gives 13 cycles, R=6 gives 7 cycles.
- ready_o is combinational from the FSM state. done_o and err_o are registered.
- round_result_i must settle within one clock period. The controller adds no pipelining to the round path.

## Test plan
- Reset check: drive reset_i for 2 cycles -> ready_o=1, done_o=0, err_o=0, round_o=0, state_o=0.
- p^a sequencing: use a stub round_result_i = perm_state_o with word 0 incremented by 1. Start with R=12 and state_i word0=0x100 -> round_o steps 0..11 across cycles t+1..t+12; done_o=1 at t+13; state_o word0=0x10C.
- p^b sequencing: same stub, start with R=6 and word0=0 -> round_o steps 6..11; done_o at t+7; word0=0x6; ready_o back at t+8.
- Real datapath: connect the actual round logic, load state 0x80400c0600000000 followed by key/nonce words from a known-answer test, run R=12 -> state_o matches the ASCON-128 initialization KAT value before the key XOR.
- Illegal rounds and busy start:
  - rounds_i=0 -> err_o pulses once, FSM stays IDLE.
  - rounds_i=13 -> err_o pulses once, FSM stays IDLE.
  - start_i=1 at cycle t+3 of an R=12 run -> ignored; done_o still occurs at t+13.
- Reset mid-run: assert reset_i at cycle t+5 of an R=12 run -> no done_o at any point, state_o=0, ready_o=1 from the next cycle; a new start then completes normally.
